// File: rtl/bit_serializer.sv
// bit_serializer: takes WIDTH-bit words over a valid/ready handshake and
// emits them one bit per clock on out_bit. A one-word pending buffer lets
// consecutive words stream with no gap, and hold freezes the bit stream
// without losing any data.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] sh_shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             pend_full, pend_full_n;
  logic             out_bit_q, out_bit_n;
  logic             accept;

  // The shifter always moves toward the end that feeds out_bit.
  assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  assign in_ready  = !pend_full;
  assign accept    = in_valid && !pend_full;
  assign out_valid = (state == SHIFT);
  assign out_bit   = out_bit_q;
  assign busy      = out_valid | pend_full;

  // Next-state logic: hold only freezes the shifter side; the pending
  // buffer keeps accepting so upstream never loses a word.
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    pend_n      = pend;
    pend_full_n = pend_full;
    out_bit_n   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          sh_n    = in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (hold) begin
          if (accept) begin
            pend_n      = in_data;
            pend_full_n = 1'b1;
          end
        end else if (cnt != LAST) begin
          sh_n  = sh_shifted;
          cnt_n = cnt + 1'b1;
          if (accept) begin
            pend_n      = in_data;
            pend_full_n = 1'b1;
          end
        end else if (pend_full) begin
          sh_n        = pend;
          cnt_n       = '0;
          pend_full_n = 1'b0;
        end else if (accept) begin
          sh_n  = in_data;
          cnt_n = '0;
        end else begin
          sh_n    = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == SHIFT) begin
      out_bit_n = MSB_FIRST ? sh_n[WIDTH-1] : sh_n[0];
    end
  end

  // State register; reset discards both the word in flight and the pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      out_bit_q <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      pend_full <= pend_full_n;
      out_bit_q <= out_bit_n;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share
// the same stimulus and are compared every cycle against a word-level model,
// plus literal bit streams for the directed scenarios.
module tb_bit_serializer;

  typedef bit bq_t[$];
  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data;
  logic       in_valid;
  logic       hold;

  logic m_ready, m_bit, m_valid, m_busy;
  logic l_ready, l_bit, l_valid, l_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Word-level model: current word, number of its bits still to show, pending words.
  logic [7:0] m_word = 8'h00;
  int         m_left = 0;
  logic [7:0] m_pend[$];

  bq_t cap_m, cap_l, mdl_m, mdl_l;
  iq_t cyc_m, cyc_l, cyc_mm, cyc_ml;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .hold(hold), .out_bit(m_bit), .out_valid(m_valid),
    .busy(m_busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .hold(hold), .out_bit(l_bit), .out_valid(l_valid),
    .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic [7:0] data, logic valid, logic hld);
    in_data  = data;
    in_valid = valid;
    hold     = hld;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_m.delete(); cap_l.delete(); mdl_m.delete(); mdl_l.delete();
    cyc_m.delete(); cyc_l.delete(); cyc_mm.delete(); cyc_ml.delete();
  endtask

  task automatic check_stream(string name, bq_t bits, iq_t cy, logic [31:0] exp, int n);
    logic [31:0] got;
    got = '0;
    checkOutput({name, " length"}, bits.size(), n);
    if (bits.size() == n && n > 0) begin
      for (int i = 0; i < n; i++) got = {got[30:0], bits[i]};
      checkOutput({name, " bits"}, got, exp);
      checkOutput({name, " contiguous"}, cy[n-1] - cy[0] + 1, n);
    end
  endtask

  // Model update on each edge, using the inputs that were stable before it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_word = 8'h00;
      m_pend.delete();
    end else begin
      bit acc;
      cyc++;
      acc = in_valid && (m_pend.size() == 0);
      if (m_left == 0) begin
        if (acc) begin m_word = in_data; m_left = 8; end
      end else if (hold) begin
        if (acc) m_pend.push_back(in_data);
      end else if (m_left > 1) begin
        m_left--;
        if (acc) m_pend.push_back(in_data);
      end else if (m_pend.size() != 0) begin
        m_word = m_pend.pop_front();
        m_left = 8;
      end else if (acc) begin
        m_word = in_data;
        m_left = 8;
      end else begin
        m_left = 0;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    logic ev, em, el, er, eb;
    int idx;
    ev  = (m_left != 0);
    idx = 8 - m_left;
    em  = ev ? m_word[7 - idx] : 1'b0;
    el  = ev ? m_word[idx] : 1'b0;
    er  = (m_pend.size() == 0);
    eb  = ev || !er;
    checkOutput("msb out_valid", m_valid, ev);
    checkOutput("msb out_bit",   m_bit,   em);
    checkOutput("msb in_ready",  m_ready, er);
    checkOutput("msb busy",      m_busy,  eb);
    checkOutput("lsb out_valid", l_valid, ev);
    checkOutput("lsb out_bit",   l_bit,   el);
    checkOutput("lsb in_ready",  l_ready, er);
    checkOutput("lsb busy",      l_busy,  eb);
    if (m_valid) begin cap_m.push_back(m_bit); cyc_m.push_back(cyc); end
    if (l_valid) begin cap_l.push_back(l_bit); cyc_l.push_back(cyc); end
    if (ev) begin
      mdl_m.push_back(em); cyc_mm.push_back(cyc);
      mdl_l.push_back(el); cyc_ml.push_back(cyc);
    end
  end

  initial begin
    applyStimulus(8'h00, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checkOutput("reset out_valid", m_valid, 1'b0);
    checkOutput("reset out_bit",   m_bit,   1'b0);
    checkOutput("reset busy",      m_busy,  1'b0);
    checkOutput("reset in_ready",  m_ready, 1'b1);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Single word, MSB first
    clear_caps();
    applyStimulus(8'hB0, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(10);
    check_stream("t1 msb dut",   cap_m, cyc_m,  32'hB0, 8);
    check_stream("t1 msb model", mdl_m, cyc_mm, 32'hB0, 8);

    // Back-to-back words with the second one landing in the pending buffer
    clear_caps();
    applyStimulus(8'hB0, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h0B, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("t2 in_ready while pending", m_ready, 1'b0);
    checkOutput("t2 busy while pending",     m_busy,  1'b1);
    idle(20);
    check_stream("t2 msb dut",   cap_m, cyc_m,  32'hB00B, 16);
    check_stream("t2 msb model", mdl_m, cyc_mm, 32'hB00B, 16);

    // Hold for three edges after the second bit
    clear_caps();
    applyStimulus(8'hB0, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b1); idle(1);
    checkOutput("t3 held out_bit",   m_bit,   1'b0);
    checkOutput("t3 held out_valid", m_valid, 1'b1);
    idle(2);
    checkOutput("t3 still held out_bit", m_bit, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(12);
    check_stream("t3 msb dut",   cap_m, cyc_m,  32'h430, 11);
    check_stream("t3 msb model", mdl_m, cyc_mm, 32'h430, 11);

    // LSB-first ordering
    clear_caps();
    applyStimulus(8'h0D, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(10);
    check_stream("t4 lsb dut",   cap_l, cyc_l,  32'hB0, 8);
    check_stream("t4 lsb model", mdl_l, cyc_ml, 32'hB0, 8);
    check_stream("t4 msb dut",   cap_m, cyc_m,  32'h0D, 8);

    // Reset mid-word with a pending word
    applyStimulus(8'hB0, 1'b1, 1'b0); idle(1);
    applyStimulus(8'hFF, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(1);
    checkOutput("t5 busy before reset",     m_busy,  1'b1);
    checkOutput("t5 in_ready before reset", m_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5 async out_valid", m_valid, 1'b0);
    checkOutput("t5 async busy",      m_busy,  1'b0);
    checkOutput("t5 async in_ready",  m_ready, 1'b1);
    checkOutput("t5 async lsb valid", l_valid, 1'b0);
    idle(2);
    reset = 1'b0;
    clear_caps();
    idle(12);
    checkOutput("t5 residual msb bits", cap_m.size(), 0);
    checkOutput("t5 residual lsb bits", cap_l.size(), 0);

    // Second word offered exactly on the last-bit edge
    clear_caps();
    applyStimulus(8'hB0, 1'b1, 1'b0); idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(7);
    applyStimulus(8'h0B, 1'b1, 1'b0);
    checkOutput("t6 in_ready on last bit", m_ready, 1'b1);
    idle(1);
    applyStimulus(8'h00, 1'b0, 1'b0); idle(12);
    check_stream("t6 msb dut",   cap_m, cyc_m,  32'hB00B, 16);
    check_stream("t6 msb model", mdl_m, cyc_mm, 32'hB00B, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
